// File: rtl/scsi_ic_responder_if.sv
// scsi_ic_responder_if: host strobe/data bus and device byte streams of the SCSI IC responder
interface scsi_ic_responder_if;
    logic       scsi_cs;
    logic       dack;
    logic       re;
    logic       we;
    logic       a0;
    logic [7:0] din;
    logic [7:0] dout;
    logic       doe;
    logic       cdreq_n;
    logic       intr;
    logic [7:0] dev_din;
    logic       dev_valid;
    logic       dev_ready;
    logic [7:0] dev_dout;
    logic       dev_ovalid;
    logic       dev_ordy;

    modport slave (
        input  scsi_cs, dack, re, we, a0, din, dev_din, dev_valid, dev_ordy,
        output dout, doe, cdreq_n, intr, dev_ready, dev_dout, dev_ovalid
    );

    modport master (
        output scsi_cs, dack, re, we, a0, din, dev_din, dev_valid, dev_ordy,
        input  dout, doe, cdreq_n, intr, dev_ready, dev_dout, dev_ovalid
    );
endinterface

// File: rtl/scsi_ic_responder.sv
// scsi_ic_responder: stands in for the SCSI IC, serving DMA/register strobes from a byte FIFO and transfer counter
module scsi_ic_responder #(
    parameter int DEPTH = 12,
    parameter int TC_W  = 24
) (
    input logic CLK,
    input logic nRESET,
    scsi_ic_responder_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic            re_q, we_q, dack_q, cs_q, a0_q, sb_q;
    logic [7:0]      din_q;
    logic [4:0]      ptr_q, ptr_d;
    logic [TC_W-1:0] tc_q, tc_d;
    logic            dir_q, dir_d, busy_q, busy_d, int_q, int_d, err_q, err_d;
    logic [7:0]      dout_q, dout_d;
    logic            doe_q, doe_d, cdreq_q, cdreq_d, sb_d;
    logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic re_rise, we_fall, dma_rd, dma_wr, reg_rd, reg_wr;
    logic full, empty, dev_push, dev_pop, push, pop, flush;
    logic [7:0] head, aux, reg_val, push_byte;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Strobe edge detection, access classification and FIFO status
    always_comb begin
        re_rise  = bus.re & ~re_q;
        we_fall  = we_q & ~bus.we;
        dma_rd   = re_rise & bus.dack;
        dma_wr   = we_fall & dack_q;
        reg_rd   = re_rise & bus.scsi_cs & ~bus.dack;
        reg_wr   = we_fall & cs_q & ~dack_q;
        full     = cnt_q == CW'(DEPTH);
        empty    = cnt_q == '0;
        head     = mem_q[rp_q];
        dev_push = dir_q & busy_q & ~full & bus.dev_valid;
        dev_pop  = ~dir_q & ~empty & bus.dev_ordy;
        aux      = {int_q, busy_q, 4'b0, err_q, ~cdreq_q};
    end

    // Register map read mux
    always_comb begin
        case (ptr_q)
            5'h12:   reg_val = tc_q[23:16];
            5'h13:   reg_val = tc_q[15:8];
            5'h14:   reg_val = tc_q[7:0];
            5'h15:   reg_val = {7'b0, dir_q};
            5'h17:   reg_val = {int_q, err_q, 6'b0};
            default: reg_val = 8'h00;
        endcase
    end

    // Next-state: DMA transfers, register accesses, commands and FIFO bookkeeping
    always_comb begin
        ptr_d     = ptr_q;
        tc_d      = tc_q;
        dir_d     = dir_q;
        busy_d    = busy_q;
        int_d     = int_q;
        err_d     = err_q;
        dout_d    = dout_q;
        mem_d     = mem_q;
        push      = dev_push;
        pop       = dev_pop;
        push_byte = bus.dev_din;
        flush     = 1'b0;
        if (dma_rd) begin
            if (~busy_q | ~dir_q | empty) begin
                err_d  = 1'b1;
                dout_d = 8'hFF;
            end else begin
                dout_d = head;
                pop    = 1'b1;
                tc_d   = tc_q - 1'b1;
            end
        end
        if (dma_wr) begin
            if (~busy_q | dir_q | full) begin
                err_d = 1'b1;
            end else begin
                push      = 1'b1;
                push_byte = din_q;
                tc_d      = tc_q - 1'b1;
            end
        end
        if (busy_q && tc_q != '0 && tc_d == '0) begin
            busy_d = 1'b0;
            int_d  = 1'b1;
        end
        if (reg_rd) begin
            dout_d = bus.a0 ? reg_val : aux;
            if (bus.a0 && ptr_q == 5'h17) begin
                int_d = 1'b0;
                err_d = 1'b0;
            end
            if (bus.a0 && ptr_q != 5'h18)
                ptr_d = ptr_q + 1'b1;
        end
        if (reg_wr) begin
            if (~a0_q) begin
                ptr_d = din_q[4:0];
            end else begin
                case (ptr_q)
                    5'h12: tc_d[23:16] = din_q;
                    5'h13: tc_d[15:8]  = din_q;
                    5'h14: tc_d[7:0]   = din_q;
                    5'h15: dir_d       = din_q[0];
                    5'h18: begin
                        if (din_q == 8'h20) begin
                            if (tc_q == '0) int_d = 1'b1;
                            else busy_d = 1'b1;
                        end else if (din_q == 8'h00) begin
                            busy_d = 1'b0;
                            int_d  = 1'b1;
                            flush  = 1'b1;
                        end
                    end
                    default: ;
                endcase
                if (ptr_q != 5'h18)
                    ptr_d = ptr_q + 1'b1;
            end
        end
        if (push)
            mem_d[wp_q] = push_byte;
        wp_d  = push ? inc(wp_q) : wp_q;
        rp_d  = pop ? inc(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
        if (flush) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end
        sb_d    = bus.dack & (bus.re | bus.we);
        doe_d   = bus.re & (bus.dack | bus.scsi_cs);
        cdreq_d = ~(busy_q & (tc_q != '0) & (dir_q ? ~empty : ~full) & ~(sb_d | sb_q));
    end

    // State registers; reset drops any in-flight transfer
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            dack_q  <= 1'b0;
            cs_q    <= 1'b0;
            a0_q    <= 1'b0;
            din_q   <= 8'h00;
            sb_q    <= 1'b0;
            ptr_q   <= '0;
            tc_q    <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            int_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 8'h00;
            doe_q   <= 1'b0;
            cdreq_q <= 1'b1;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            mem_q   <= '{default: 8'h00};
        end else begin
            re_q    <= bus.re;
            we_q    <= bus.we;
            dack_q  <= bus.dack;
            cs_q    <= bus.scsi_cs;
            a0_q    <= bus.a0;
            din_q   <= bus.din;
            sb_q    <= sb_d;
            ptr_q   <= ptr_d;
            tc_q    <= tc_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            int_q   <= int_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            doe_q   <= doe_d;
            cdreq_q <= cdreq_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.doe        = doe_q;
    assign bus.cdreq_n    = cdreq_q;
    assign bus.intr       = int_q;
    assign bus.dev_ready  = dir_q & busy_q & ~full;
    assign bus.dev_ovalid = ~dir_q & ~empty;
    assign bus.dev_dout   = bus.dev_ovalid ? head : 8'h00;
endmodule

// File: tb/tb_scsi_ic_responder.sv
// tb_scsi_ic_responder: directed sequence with random data against a queue-based reference model
module tb_scsi_ic_responder;
    localparam int DEPTH = 12;

    logic CLK = 1'b0;
    logic nRESET = 1'b0;
    scsi_ic_responder_if bus();

    scsi_ic_responder #(.DEPTH(DEPTH), .TC_W(24)) dut (.CLK(CLK), .nRESET(nRESET), .bus(bus));

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mq[$];
    logic [23:0] mtc;
    logic        mdir, mbusy, mint, merr;
    logic [4:0]  mptr;

    function automatic logic mdreq();
        return mbusy && mtc != 0 && (mdir ? mq.size() != 0 : mq.size() != DEPTH);
    endfunction

    function automatic logic [7:0] maux();
        return {mint, mbusy, 4'b0, merr, mdreq()};
    endfunction

    function automatic logic [7:0] mreg();
        case (mptr)
            5'h12:   return mtc[23:16];
            5'h13:   return mtc[15:8];
            5'h14:   return mtc[7:0];
            5'h15:   return {7'b0, mdir};
            5'h17:   return {mint, merr, 6'b0};
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_reset();
        mq.delete();
        mtc = 0; mdir = 0; mbusy = 0; mint = 0; merr = 0; mptr = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_cdreq"}, bus.cdreq_n, 1);
        chk({tag, "_dout"}, bus.dout, 0);
        chk({tag, "_doe"}, bus.doe, 0);
        chk({tag, "_intr"}, bus.intr, 0);
        chk({tag, "_ready"}, bus.dev_ready, 0);
        chk({tag, "_ovalid"}, bus.dev_ovalid, 0);
        chk({tag, "_ddout"}, bus.dev_dout, 0);
    endtask

    task automatic reg_wr(input logic a0, input logic [7:0] d);
        bus.scsi_cs = 1; bus.a0 = a0; bus.din = d; bus.we = 1;
        tick(2);
        bus.we = 0; bus.scsi_cs = 0; bus.a0 = 0;
        tick(3);
        if (!a0) mptr = d[4:0];
        else begin
            case (mptr)
                5'h12: mtc[23:16] = d;
                5'h13: mtc[15:8] = d;
                5'h14: mtc[7:0] = d;
                5'h15: mdir = d[0];
                5'h18: begin
                    if (d == 8'h20) begin
                        if (mtc == 0) mint = 1; else mbusy = 1;
                    end else if (d == 8'h00) begin
                        mbusy = 0; mint = 1; mq.delete();
                    end
                end
                default: ;
            endcase
            if (mptr != 5'h18) mptr++;
        end
    endtask

    task automatic reg_rd(input logic a0, input string tag);
        logic [7:0] exp;
        exp = a0 ? mreg() : maux();
        bus.scsi_cs = 1; bus.a0 = a0; bus.re = 1;
        tick(1);
        chk(tag, bus.dout, exp);
        chk({tag, "_doe"}, bus.doe, 1);
        tick(1);
        bus.re = 0; bus.scsi_cs = 0; bus.a0 = 0;
        tick(3);
        if (a0) begin
            if (mptr == 5'h17) begin mint = 0; merr = 0; end
            if (mptr != 5'h18) mptr++;
        end
    endtask

    task automatic dma_rd(input string tag);
        logic [7:0] exp;
        chk({tag, "_cdreq"}, bus.cdreq_n, !mdreq());
        if (!mbusy || !mdir || mq.size() == 0) begin
            exp = 8'hFF; merr = 1;
        end else begin
            exp = mq.pop_front(); mtc--;
            if (mtc == 0) begin mbusy = 0; mint = 1; end
        end
        bus.dack = 1; bus.re = 1;
        tick(1);
        chk(tag, bus.dout, exp);
        tick(1);
        bus.dack = 0; bus.re = 0;
        tick(3);
    endtask

    task automatic dma_wr(input logic [7:0] d, input string tag);
        chk({tag, "_cdreq"}, bus.cdreq_n, !mdreq());
        if (!mbusy || mdir || mq.size() == DEPTH) merr = 1;
        else begin
            mq.push_back(d); mtc--;
            if (mtc == 0) begin mbusy = 0; mint = 1; end
        end
        bus.dack = 1; bus.we = 1; bus.din = d;
        tick(2);
        bus.we = 0; bus.dack = 0;
        tick(3);
    endtask

    task automatic dev_push(input logic [7:0] d);
        int w = 0;
        while (!bus.dev_ready && w < 20) begin tick(1); w++; end
        chk("dev_ready", bus.dev_ready, 1);
        bus.dev_din = d; bus.dev_valid = 1;
        tick(1);
        bus.dev_valid = 0;
        tick(3);
        mq.push_back(d);
    endtask

    task automatic drain(input int n);
        bus.dev_ordy = 1;
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!bus.dev_ovalid && w < 20) begin tick(1); w++; end
            chk("drain_valid", bus.dev_ovalid, 1);
            chk("drain_data", bus.dev_dout, mq.size() != 0 ? mq.pop_front() : 8'hxx);
            tick(1);
        end
        bus.dev_ordy = 0;
        tick(1);
        chk("drain_empty", bus.dev_ovalid, 0);
    endtask

    task automatic set_tc(input logic [23:0] v);
        reg_wr(0, 8'h12); reg_wr(1, v[23:16]); reg_wr(1, v[15:8]); reg_wr(1, v[7:0]);
    endtask

    task automatic set_dir(input logic d);
        reg_wr(0, 8'h15); reg_wr(1, {7'b0, d});
    endtask

    task automatic cmd(input logic [7:0] c);
        reg_wr(0, 8'h18); reg_wr(1, c);
    endtask

    task automatic read_tc(input string tag);
        reg_wr(0, 8'h12);
        reg_rd(1, {tag, "_hi"}); reg_rd(1, {tag, "_mid"}); reg_rd(1, {tag, "_lo"});
    endtask

    task automatic status(input string tag);
        reg_wr(0, 8'h17); reg_rd(1, tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bus.scsi_cs = 0; bus.dack = 0; bus.re = 0; bus.we = 0; bus.a0 = 0; bus.din = 0;
        bus.dev_din = 0; bus.dev_valid = 0; bus.dev_ordy = 0;
        m_reset();
        tick(2);
        chk_reset("reset");
        nRESET = 1;
        tick(2);

        reg_wr(0, 8'h12); reg_wr(1, 8'h00); reg_wr(1, 8'h01); reg_wr(1, 8'h02);
        read_tc("regtc");
        reg_rd(1, "ctrl_autoinc");
        reg_rd(1, "unmapped16");

        set_tc(4); set_dir(1); cmd(8'h20);
        chk("start_idle_cdreq", bus.cdreq_n, 1);
        bus.dev_din = 8'hA1; bus.dev_valid = 1;
        tick(1);
        bus.dev_valid = 0;
        mq.push_back(8'hA1);
        chk("push_lat1", bus.cdreq_n, 1);
        tick(1);
        chk("push_lat2", bus.cdreq_n, 0);
        tick(2);
        for (int i = 2; i <= 4; i++) dev_push(8'hA0 + 8'(i));
        reg_rd(0, "aux_busy");
        for (int i = 0; i < 4; i++) dma_rd("rd_data");
        chk("rd_done_intr", bus.intr, 1);
        chk("rd_done_cdreq", bus.cdreq_n, 1);
        read_tc("rd_tc");
        status("rd_status");
        chk("rd_intr_clr", bus.intr, 0);

        repeat (3) begin
            n = $urandom_range(1, 8);
            set_tc(24'(n)); set_dir(1); cmd(8'h20);
            for (int i = 0; i < n; i++) dev_push(8'($urandom));
            for (int i = 0; i < n; i++) dma_rd("rnd_rd");
            chk("rnd_intr", bus.intr, mint);
            status("rnd_status");
        end

        set_tc(3); set_dir(0); cmd(8'h20);
        for (int i = 0; i < 3; i++) dma_wr(8'($urandom), "wr");
        reg_rd(0, "wr_aux");
        chk("wr_ovalid", bus.dev_ovalid, 1);
        drain(3);
        status("wr_status");

        set_tc(20); cmd(8'h20);
        for (int i = 0; i < DEPTH; i++) dma_wr(8'($urandom), "fill");
        chk("full_cdreq", bus.cdreq_n, 1);
        dma_wr(8'h5A, "overflow");
        read_tc("full_tc");
        reg_rd(0, "full_aux");
        cmd(8'h00);
        chk("abort_ovalid", bus.dev_ovalid, 0);
        chk("abort_cdreq", bus.cdreq_n, 1);
        chk("abort_intr", bus.intr, 1);
        status("abort_status");

        set_tc(2); set_dir(1); cmd(8'h20);
        dma_rd("empty_rd");
        status("empty_status");
        cmd(8'h00);
        status("empty_abort_status");

        set_tc(0); cmd(8'h20);
        chk("tc0_intr", bus.intr, 1);
        for (int i = 0; i < 5; i++) begin
            chk("tc0_cdreq", bus.cdreq_n, 1);
            tick(1);
        end
        status("tc0_status");

        set_tc(24'($urandom_range(3, 9))); set_dir(1); cmd(8'h20);
        dev_push(8'($urandom)); dev_push(8'($urandom));
        bus.dack = 1; bus.re = 1;
        tick(1);
        nRESET = 0;
        #1;
        chk_reset("midrst");
        bus.dack = 0; bus.re = 0;
        tick(1);
        nRESET = 1;
        m_reset();
        tick(2);
        reg_rd(0, "post_rst_aux");
        read_tc("post_rst_tc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
